eth_tx_4way_dispatch: RTL and testbench



---
 rtl/eth_tx_4way_dispatch.sv | 158 +++++++++++++++
 tb/tb_eth_tx_4way_dispatch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_4way_dispatch.sv
// Steers whole packets from one input stream to one of four output streams, or drops them.
// Define ETH_TX_DISPATCH_STATS_EN to build the per-channel and drop packet counters.
module eth_tx_4way_dispatch #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned MOD_WIDTH   = 3,
    parameter int unsigned FLAGS_WIDTH = 4,
    localparam int unsigned NUM_STREAMS = 4
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic [2:0]                        i_sel,
    input  logic [NUM_STREAMS-1:0]            i_active_ch,
    // input stream
    input  logic                              i_in_valid,
    input  logic [DATA_WIDTH-1:0]             i_in_data,
    input  logic                              i_in_sop,
    input  logic                              i_in_eop,
    input  logic [MOD_WIDTH-1:0]              i_in_mod,
    input  logic [FLAGS_WIDTH-1:0]            i_in_flags,
    output logic                              o_in_ready,
    // output streams, channel n occupies slice n of each vector
    output logic [NUM_STREAMS-1:0]            o_out_valid,
    output logic [NUM_STREAMS*DATA_WIDTH-1:0] o_out_data,
    output logic [NUM_STREAMS-1:0]            o_out_sop,
    output logic [NUM_STREAMS-1:0]            o_out_eop,
    output logic [NUM_STREAMS*MOD_WIDTH-1:0]  o_out_mod,
    output logic [NUM_STREAMS*FLAGS_WIDTH-1:0] o_out_flags,
    input  logic [NUM_STREAMS-1:0]            i_out_ready,
    // status
    output logic [NUM_STREAMS-1:0]            o_active_ch,
    output logic                              o_frame_start,
    output logic                              o_sop_err,
    output logic [NUM_STREAMS*CNT_WIDTH-1:0]  o_pkt_cnt,
    output logic [CNT_WIDTH-1:0]              o_drop_cnt
);

    localparam logic [1:0] SW_IDLE  = 2'd0;
    localparam logic [1:0] SW_FRAME = 2'd1;
    localparam logic [1:0] SW_DROP  = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [1:0]             dest_q, dest_d;
    logic [NUM_STREAMS-1:0] active_ch_q, active_ch_d;
    logic                   frame_start_q, frame_start_d;
    logic                   sop_err_q, sop_err_d;
    logic [NUM_STREAMS-1:0] valid_c;
    logic                   ready_c;

    always_comb begin
        state_d       = state_q;
        dest_d        = dest_q;
        active_ch_d   = active_ch_q;
        frame_start_d = 1'b0;
        sop_err_d     = 1'b0;
        valid_c       = '0;
        ready_c       = 1'b0;
        case (state_q)
            SW_IDLE: begin
                // SOP beats are only looked at here; they are consumed in FRAME/DROP.
                if (i_in_valid && !i_in_sop) begin
                    ready_c   = 1'b1;
                    sop_err_d = 1'b1;
                end else if (i_in_valid && i_sel[2]) begin
                    state_d = SW_DROP;
                end else if (i_in_valid && !i_active_ch[i_sel[1:0]]) begin
                    dest_d        = i_sel[1:0];
                    active_ch_d   = NUM_STREAMS'(1) << i_sel[1:0];
                    frame_start_d = 1'b1;
                    state_d       = SW_FRAME;
                end
            end
            SW_FRAME: begin
                valid_c[dest_q] = i_in_valid;
                ready_c         = i_out_ready[dest_q];
                if (i_in_valid && ready_c && i_in_eop) begin
                    state_d     = SW_IDLE;
                    active_ch_d = '0;
                end
            end
            SW_DROP: begin
                ready_c = 1'b1;
                if (i_in_valid && i_in_eop) begin
                    state_d = SW_IDLE;
                end
            end
            default: begin
                state_d     = SW_IDLE;
                active_ch_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= SW_IDLE;
            dest_q        <= 2'd0;
            active_ch_q   <= '0;
            frame_start_q <= 1'b0;
            sop_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            dest_q        <= dest_d;
            active_ch_q   <= active_ch_d;
            frame_start_q <= frame_start_d;
            sop_err_q     <= sop_err_d;
        end
    end

    // Handshakes are forced low combinationally while reset is held.
    assign o_in_ready    = ready_c & i_reset_n;
    assign o_out_valid   = valid_c & {NUM_STREAMS{i_reset_n}};
    assign o_out_data    = {NUM_STREAMS{i_in_data}};
    assign o_out_sop     = {NUM_STREAMS{i_in_sop}};
    assign o_out_eop     = {NUM_STREAMS{i_in_eop}};
    assign o_out_mod     = {NUM_STREAMS{i_in_mod}};
    assign o_out_flags   = {NUM_STREAMS{i_in_flags}};
    assign o_active_ch   = active_ch_q;
    assign o_frame_start = frame_start_q;
    assign o_sop_err     = sop_err_q;

`ifdef ETH_TX_DISPATCH_STATS_EN
    logic [NUM_STREAMS-1:0][CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]                  drop_cnt_q, drop_cnt_d;
    logic                                  eop_fwd, eop_drop;

    assign eop_fwd  = (state_q == SW_FRAME) && i_in_valid && o_in_ready && i_in_eop;
    assign eop_drop = (state_q == SW_DROP) && i_in_valid && o_in_ready && i_in_eop;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (eop_fwd) begin
            pkt_cnt_d[dest_q] = pkt_cnt_q[dest_q] + 1'b1;
        end
        if (eop_drop) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_pkt_cnt  = pkt_cnt_q;
    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_pkt_cnt  = '0;
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_tx_4way_dispatch.sv
// Randomized packet-level bench for eth_tx_4way_dispatch; expectations follow the packet
// rules (grant after one decision cycle, steer to the selected channel, drop on sel[2]).
module tb_eth_tx_4way_dispatch;

`ifdef ETH_TX_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   sel;
    logic [3:0]   act_in;
    logic         in_valid, in_sop, in_eop, in_ready;
    logic [63:0]  in_data;
    logic [2:0]   in_mod;
    logic [3:0]   in_flags;
    logic [3:0]   out_valid, out_sop, out_eop, out_ready;
    logic [255:0] out_data;
    logic [11:0]  out_mod;
    logic [15:0]  out_flags;
    logic [3:0]   active_ch;
    logic         frame_start, sop_err;
    logic [127:0] pkt_cnt;
    logic [31:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int exp_pkt[4];
    int exp_drop;

    eth_tx_4way_dispatch dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_sel        (sel),
        .i_active_ch  (act_in),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .i_in_sop     (in_sop),
        .i_in_eop     (in_eop),
        .i_in_mod     (in_mod),
        .i_in_flags   (in_flags),
        .o_in_ready   (in_ready),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .o_out_sop    (out_sop),
        .o_out_eop    (out_eop),
        .o_out_mod    (out_mod),
        .o_out_flags  (out_flags),
        .i_out_ready  (out_ready),
        .o_active_ch  (active_ch),
        .o_frame_start(frame_start),
        .o_sop_err    (sop_err),
        .o_pkt_cnt    (pkt_cnt),
        .o_drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [63:0] d);
        in_valid = v;
        in_sop   = s;
        in_eop   = e;
        in_data  = d;
        in_mod   = 3'($urandom);
        in_flags = 4'($urandom);
    endtask

    task automatic check_cnts();
        for (int n = 0; n < 4; n++) begin
            check("pkt_cnt", 64'(pkt_cnt[n*32 +: 32]), STATS ? 64'(exp_pkt[n]) : 64'd0);
        end
        check("drop_cnt", 64'(drop_cnt), STATS ? 64'(exp_drop) : 64'd0);
    endtask

    // Broadcast fields must appear on an arbitrary output unchanged.
    task automatic check_bcast(input logic [63:0] d);
        int k;
        k = $urandom_range(0, 3);
        check("bc_data", out_data[k*64 +: 64], d);
        check("bc_ctl", {out_sop[k], out_eop[k], out_mod[k*3 +: 3], out_flags[k*4 +: 4]},
              {in_sop, in_eop, in_mod, in_flags});
    endtask

    task automatic idle_gap(input int n);
        for (int c = 0; c < n; c++) begin
            drive(1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom});
            sel       = 3'($urandom);
            act_in    = 4'($urandom);
            out_ready = 4'($urandom);
            #3;
            check("gap_rdy", 64'(in_ready), 0);
            check("gap_vld", 64'(out_valid), 0);
            check("gap_act", 64'(active_ch), 0);
            check("gap_err", 64'(sop_err), 0);
            step();
        end
    endtask

    // Send one packet: SOP waits while its channel is busy, then one decision cycle,
    // then beats flow with the selected channel's ready (or ready=1 when dropping).
    task automatic send_pkt(input logic [2:0] psel, input int nbeats, input int busy,
                            input bit all_rdy);
        logic [63:0] bd[8];
        logic [3:0]  oh;
        logic [3:0]  ordy;
        logic        drop, v, rdy_exp;
        int          beat;
        bit          first;
        drop = psel[2];
        oh   = 4'b0001 << psel[1:0];
        if (drop) busy = 0;
        for (int b = 0; b < nbeats; b++) bd[b] = {$urandom, $urandom};

        for (int c = 0; c <= busy; c++) begin
            drive(1'b1, 1'b1, nbeats == 1, bd[0]);
            sel       = psel;
            act_in    = (c < busy) ? (4'($urandom) | oh) : (4'($urandom) & ~oh);
            out_ready = all_rdy ? 4'hF : 4'($urandom);
            #3;
            check("dec_rdy", 64'(in_ready), 0);
            check("dec_vld", 64'(out_valid), 0);
            check("dec_act", 64'(active_ch), 0);
            check("dec_fs", 64'(frame_start), 0);
            step();
        end

        beat  = 0;
        first = 1'b1;
        while (beat < nbeats) begin
            v = (beat == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
            drive(v, beat == 0, beat == nbeats - 1, bd[beat]);
            sel       = 3'($urandom);
            act_in    = 4'($urandom);
            ordy      = all_rdy ? 4'hF : 4'($urandom);
            out_ready = ordy;
            #3;
            rdy_exp = drop ? 1'b1 : ordy[psel[1:0]];
            check("pkt_rdy", 64'(in_ready), 64'(rdy_exp));
            check("pkt_vld", 64'(out_valid), (v && !drop) ? 64'(oh) : 64'd0);
            check("pkt_act", 64'(active_ch), drop ? 64'd0 : 64'(oh));
            check("pkt_fs", 64'(frame_start), 64'(first && !drop));
            if (v) check_bcast(bd[beat]);
            if (v && rdy_exp) begin
                if (beat == nbeats - 1) begin
                    if (drop) exp_drop++;
                    else exp_pkt[psel[1:0]]++;
                end
                beat++;
            end
            first = 1'b0;
            step();
        end
        check_cnts();
    endtask

    initial begin
        for (int n = 0; n < 4; n++) exp_pkt[n] = 0;
        exp_drop  = 0;
        rst_n     = 1'b0;
        sel       = 3'd0;
        act_in    = 4'd0;
        out_ready = 4'hF;
        drive(1'b1, 1'b0, 1'b0, 64'h0);
        step();
        step();
        #3;
        check("rst_rdy", 64'(in_ready), 0);
        check("rst_vld", 64'(out_valid), 0);
        check("rst_act", 64'(active_ch), 0);
        check("rst_fs", 64'(frame_start), 0);
        check("rst_err", 64'(sop_err), 0);
        check_cnts();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        step();
        rst_n = 1'b1;
        idle_gap(2);

        // directed cases
        send_pkt(3'd1, 4, 0, 1'b1);
        send_pkt(3'd2, 4, 10, 1'b0);
        send_pkt(3'b100, 3, 0, 1'b0);
        send_pkt(3'd0, 1, 0, 1'b0);
        send_pkt(3'd3, 1, 0, 1'b0);
        send_pkt(3'd0, 1, 0, 1'b0);

        // orphan beat while idle
        drive(1'b1, 1'b0, 1'b0, 64'h1234);
        out_ready = 4'hF;
        #3;
        check("orph_rdy", 64'(in_ready), 1);
        check("orph_vld", 64'(out_valid), 0);
        check("orph_err0", 64'(sop_err), 0);
        step();
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        #3;
        check("orph_err1", 64'(sop_err), 1);
        step();
        #3;
        check("orph_err2", 64'(sop_err), 0);

        // 5-beat packet to channel 0, reset during beat 2
        sel    = 3'd0;
        act_in = 4'd0;
        drive(1'b1, 1'b1, 1'b0, 64'hA0);
        #3;
        check("r5_dec", 64'(in_ready), 0);
        step();
        #3;
        check("r5_fs", 64'(frame_start), 1);
        check("r5_b0", 64'(out_valid), 64'b0001);
        step();
        drive(1'b1, 1'b0, 1'b0, 64'hA1);
        #3;
        check("r5_b1", 64'(out_valid), 64'b0001);
        step();
        drive(1'b1, 1'b0, 1'b0, 64'hA2);
        rst_n = 1'b0;
        #3;
        check("r5_rst_rdy", 64'(in_ready), 0);
        check("r5_rst_vld", 64'(out_valid), 0);
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) exp_pkt[n] = 0;
        exp_drop = 0;
        for (int b = 2; b < 5; b++) begin
            drive(1'b1, 1'b0, b == 4, 64'hA0 + 64'(b));
            #3;
            check("r5_orph_rdy", 64'(in_ready), 1);
            check("r5_orph_vld", 64'(out_valid), 0);
            check("r5_orph_act", 64'(active_ch), 0);
            check("r5_orph_err", 64'(sop_err), 64'(b > 2));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 64'h0);
        #3;
        check("r5_err_last", 64'(sop_err), 1);
        check_cnts();
        step();

        // randomized packets
        for (int p = 0; p < 60; p++) begin
            idle_gap($urandom_range(0, 2));
            send_pkt(3'($urandom_range(0, 7)), $urandom_range(1, 5), $urandom_range(0, 3),
                     1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
